baud_ctrl: RTL and testbench



---
 rtl/baud_ctrl.sv | 100 ++++++++++
 tb/tb_baud_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_ctrl.sv
// SPART baud-rate controller: latches the divisor from bus writes, sequences the down counter's
// load strobe and turns each expiry into a one-cycle baud enable. Optional tick: BAUD_TX_TICK_EN.
module baud_ctrl #(
    parameter logic [1:0] LO_ADDR = 2'b10,
    parameter logic [1:0] HI_ADDR = 2'b11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iocs,
    input  logic        iorw,
    input  logic [1:0]  ioaddr,
    input  logic [7:0]  databus_in,
    input  logic [15:0] count_in,
    output logic [15:0] div_buf,
    output logic        load,
    output logic        baud_en,
    output logic        configured,
    output logic        tx_tick
);

    typedef enum logic [1:0] {
        StCfgWait,
        StLoad,
        StRun
    } state_e;

    state_e state;

    logic bus_wr;
    logic wr_lo;
    logic wr_hi;
    logic expired;
    logic baud_next;

    assign bus_wr  = iocs && !iorw;
    assign wr_lo   = bus_wr && (ioaddr == LO_ADDR);
    assign wr_hi   = bus_wr && (ioaddr == HI_ADDR);
    assign expired = (state == StRun) && (count_in == 16'h0000);

    // A high-byte write restarts the sequence, so the expiry it coincides with is dropped.
    assign baud_next = expired && !wr_hi;

    assign load = (state == StLoad) || expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StCfgWait;
            div_buf    <= 16'h0000;
            baud_en    <= 1'b0;
            configured <= 1'b0;
        end else begin
            if (wr_lo) begin
                div_buf[7:0] <= databus_in;
            end
            if (wr_hi) begin
                div_buf[15:8] <= databus_in;
            end
            baud_en <= baud_next;
            case (state)
                StCfgWait: begin
                    if (wr_hi) begin
                        state <= StLoad;
                    end
                end
                StLoad: begin
                    configured <= 1'b1;
                    state      <= wr_hi ? StLoad : StRun;
                end
                StRun: begin
                    if (wr_hi) begin
                        state <= StLoad;
                    end
                end
                default: state <= StCfgWait;
            endcase
        end
    end

`ifdef BAUD_TX_TICK_EN
    logic [3:0] tick_cnt;

    // tx_tick is registered alongside baud_en so both rise in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= 4'd0;
            tx_tick  <= 1'b0;
        end else begin
            tx_tick <= baud_next && (tick_cnt == 4'd15);
            if (state == StLoad) begin
                tick_cnt <= 4'd0;
            end else if (baud_next) begin
                tick_cnt <= tick_cnt + 4'd1;
            end
        end
    end
`else
    assign tx_tick = 1'b0;
`endif

endmodule

// File: tb/tb_baud_ctrl.sv
// Bench for baud_ctrl: a down-counter model closes the loop and a scoreboard holds the cycles
// on which baud_en / tx_tick are expected.
module tb_baud_ctrl;

    localparam logic [1:0] LO = 2'b10;
    localparam logic [1:0] HI = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        iocs = 1'b0;
    logic        iorw = 1'b1;
    logic [1:0]  ioaddr = 2'b00;
    logic [7:0]  databus_in = 8'h00;
    logic [15:0] count_in;
    logic [15:0] div_buf;
    logic        load;
    logic        baud_en;
    logic        configured;
    logic        tx_tick;

    logic [15:0] cnt;
    logic        force_en = 1'b0;
    logic [15:0] force_val = 16'h0000;
    logic        mon_en = 1'b0;
    logic        load_at_wr;
    int          cyc = 0;
    int          wr_cyc;
    int          n_chk = 0;
    int          n_pass = 0;
    int          baud_q[$];
    int          tick_q[$];

    baud_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .databus_in (databus_in),
        .count_in   (count_in),
        .div_buf    (div_buf),
        .load       (load),
        .baud_en    (baud_en),
        .configured (configured),
        .tx_tick    (tx_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Down counter driven by the controller's load strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= 16'h0000;
        else if (load) cnt <= div_buf;
        else           cnt <= cnt - 16'd1;
    end

    assign count_in = force_en ? force_val : cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (baud_en) begin
                if (baud_q.size() == 0) check("baud_unexpected", 32'd1, 32'd0);
                else check("baud_cycle", cyc, baud_q.pop_front());
            end
            if (tx_tick) begin
                if (tick_q.size() == 0) check("tick_unexpected", 32'd1, 32'd0);
                else check("tick_cycle", cyc, tick_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        wr_cyc     = cyc;
        iocs       = 1'b1;
        iorw       = 1'b0;
        ioaddr     = a;
        databus_in = d;
        @(negedge clk);
        load_at_wr = load;
        tick();
        iocs = 1'b0;
        iorw = 1'b1;
    endtask

    task automatic do_reset();
        mon_en   = 1'b0;
        force_en = 1'b0;
        iocs     = 1'b0;
        iorw     = 1'b1;
        baud_q.delete();
        tick_q.delete();
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_div_buf", div_buf, 0);
        check("rst_load", load, 0);
        check("rst_baud_en", baud_en, 0);
        check("rst_configured", configured, 0);
        check("rst_tx_tick", tx_tick, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drain(input string tag, input int limit);
        for (int i = 0; i < limit && (baud_q.size() + tick_q.size()) != 0; i++) @(posedge clk);
        check(tag, baud_q.size() + tick_q.size(), 0);
        mon_en = 1'b0;
        #1;
    endtask

    initial begin
        int w;
        int gaps;
        logic ld_seen, cf_seen, be_seen;

        // Divisor 0x0144: period 325
        do_reset();
        bus_write(LO, 8'h44);
        @(negedge clk);
        check("lo_no_load", load, 0);
        check("lo_not_cfg", configured, 0);
        tick();
        mon_en = 1'b1;
        bus_write(HI, 8'h01);
        w = wr_cyc;
        baud_q.push_back(w + 327);
        baud_q.push_back(w + 652);
        baud_q.push_back(w + 977);
        check("hi_wr_no_load", load_at_wr, 0);
        @(negedge clk);
        check("load_after_hi", load, 1);
        check("div_buf", div_buf, 32'h0144);
        check("cfg_during_load", configured, 0);
        tick();
        @(negedge clk);
        check("load_drop", load, 0);
        check("configured", configured, 1);
        drain("period_325", 1100);

        // Unconfigured with count_in stuck at 0
        do_reset();
        force_en  = 1'b1;
        force_val = 16'h0000;
        mon_en    = 1'b1;
        ld_seen = 1'b0;
        cf_seen = 1'b0;
        be_seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            ld_seen |= load;
            cf_seen |= configured;
            be_seen |= baud_en;
        end
        check("idle_load", ld_seen, 0);
        check("idle_cfg", cf_seen, 0);
        check("idle_baud", be_seen, 0);

        // Divisor 3, restart by HI write coinciding with an expiry
        do_reset();
        bus_write(LO, 8'h03);
        mon_en = 1'b1;
        bus_write(HI, 8'h00);
        w = wr_cyc;
        baud_q.push_back(w + 6);
        baud_q.push_back(w + 10);
        while (cyc < w + 13) tick();
        check("restart_q_empty", baud_q.size(), 0);
        check("restart_cnt_zero", count_in, 0);
        baud_q.push_back(w + 19);
        baud_q.push_back(w + 23);
        baud_q.push_back(w + 27);
        bus_write(HI, 8'h00);
        check("restart_load_old", load_at_wr, 1);
        @(negedge clk);
        check("restart_load", load, 1);
        tick();
        drain("restart_period", 40);

        // Divisor 0: continuous baud_en and load
        do_reset();
        bus_write(LO, 8'h00);
        mon_en = 1'b1;
        bus_write(HI, 8'h00);
        w = wr_cyc;
        for (int k = 3; k <= 12; k++) baud_q.push_back(w + k);
        gaps = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (!load) gaps++;
            tick();
        end
        check("div0_load_gaps", gaps, 0);
        drain("div0_cont", 20);

        // Asynchronous reset mid-run
        do_reset();
        bus_write(LO, 8'h10);
        mon_en = 1'b1;
        bus_write(HI, 8'h00);
        w = wr_cyc;
        baud_q.push_back(w + 19);
        while (cyc < w + 28) tick();
        check("mid_q_empty", baud_q.size(), 0);
        check("mid_count", count_in, 32'h0007);
        #1 rst_n = 1'b0;
        #1;
        check("async_div_buf", div_buf, 0);
        check("async_load", load, 0);
        check("async_baud_en", baud_en, 0);
        check("async_cfg", configured, 0);
        check("async_tx_tick", tx_tick, 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (50) tick();
        check("post_rst_cfg", configured, 0);
        check("post_rst_div", div_buf, 0);
        bus_write(LO, 8'h10);
        bus_write(HI, 8'h00);
        baud_q.push_back(wr_cyc + 19);
        drain("rehi_baud", 40);

        // Divisor 2: tx_tick on every 16th baud_en when enabled
        do_reset();
        bus_write(LO, 8'h02);
        mon_en = 1'b1;
        bus_write(HI, 8'h00);
        w = wr_cyc;
        for (int k = 0; k < 32; k++) baud_q.push_back(w + 5 + 3 * k);
`ifdef BAUD_TX_TICK_EN
        tick_q.push_back(w + 50);
        tick_q.push_back(w + 98);
`endif
        drain("tick_run", 120);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
